// File: rtl/line_matrix_v2_if.sv
// rtl/line_matrix_v2_if.sv - configuration strobe/field bundle for the line matrix
// Software side drives the master modport; the matrix consumes the slave modport.
interface line_matrix_v2_if #(
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 9,
  parameter int STRETCH_W = 8
);
  localparam int SRC_W = $clog2(NUM_IN + 2);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                 cfg_wr;
  logic                 cfg_commit;
  logic [IDX_W-1:0]     cfg_out_idx;
  logic [SRC_W-1:0]     cfg_src;
  logic                 cfg_invert;
  logic [STRETCH_W-1:0] cfg_stretch;
  logic                 cfg_ack;
  logic                 cfg_err;

  modport master (
    output cfg_wr, cfg_commit, cfg_out_idx, cfg_src, cfg_invert, cfg_stretch,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_commit, cfg_out_idx, cfg_src, cfg_invert, cfg_stretch,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/line_matrix_v2.sv
// rtl/line_matrix_v2.sv - synchronised input-to-output line router with invert and pulse stretch
// Double-buffered route table: writes land in the shadow, a commit copies it to the active table.
module line_matrix_v2 #(
  parameter int NUM_IN      = 8,
  parameter int NUM_OUT     = 9,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IN-1:0]  input_lines,
  output logic [NUM_OUT-1:0] output_lines,
  line_matrix_v2_if.slave    cfg
);
  localparam int SRC_W = $clog2(NUM_IN + 2);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [SRC_W-1:0] SRC_ZERO = SRC_W'(NUM_IN);
  localparam logic [SRC_W-1:0] SRC_ONE  = SRC_W'(NUM_IN + 1);
  localparam logic [STRETCH_W-1:0] STR_ONE = STRETCH_W'(1);

  // Synchronisers and edge detectors
  logic [NUM_IN-1:0]      in_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] wr_sync_q, cm_sync_q;
  logic                   wr_prev_q, cm_prev_q;
  logic                   wr_edge, cm_edge;

  // Route tables
  logic [SRC_W-1:0]     sh_src_q [NUM_OUT];
  logic [SRC_W-1:0]     sh_src_d [NUM_OUT];
  logic [NUM_OUT-1:0]   sh_inv_q, sh_inv_d;
  logic [STRETCH_W-1:0] sh_str_q [NUM_OUT];
  logic [STRETCH_W-1:0] sh_str_d [NUM_OUT];
  logic [SRC_W-1:0]     act_src_q [NUM_OUT];
  logic [NUM_OUT-1:0]   act_inv_q;
  logic [STRETCH_W-1:0] act_str_q [NUM_OUT];

  // Status
  logic ack_q, ack_d;
  logic err_q, err_d;
  logic idx_ok;

  // Datapath / stretcher
  logic [NUM_IN-1:0]    in_s;
  logic [NUM_OUT-1:0]   s_line;
  logic [NUM_OUT-1:0]   s_prev_q;
  logic [STRETCH_W-1:0] cnt_q [NUM_OUT];
  logic [STRETCH_W-1:0] cnt_d [NUM_OUT];
  logic [NUM_OUT-1:0]   out_q, out_d;

  assign in_s    = in_sync_q[SYNC_STAGES-1];
  assign wr_edge = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
  assign cm_edge = cm_sync_q[SYNC_STAGES-1] & ~cm_prev_q;
  assign idx_ok  = (32'(cfg.cfg_out_idx) < NUM_OUT);

  assign output_lines = out_q;
  assign cfg.cfg_ack  = ack_q;
  assign cfg.cfg_err  = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) in_sync_q[i] <= '0;
      wr_sync_q <= '0;
      cm_sync_q <= '0;
      wr_prev_q <= 1'b0;
      cm_prev_q <= 1'b0;
    end else begin
      in_sync_q[0] <= input_lines;
      for (int i = 1; i < SYNC_STAGES; i++) in_sync_q[i] <= in_sync_q[i-1];
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], cfg.cfg_wr};
      cm_sync_q <= {cm_sync_q[SYNC_STAGES-2:0], cfg.cfg_commit};
      wr_prev_q <= wr_sync_q[SYNC_STAGES-1];
      cm_prev_q <= cm_sync_q[SYNC_STAGES-1];
    end
  end

  // The commit copies sh_*_d so a write on the same edge is included.
  always_comb begin
    sh_src_d = sh_src_q;
    sh_inv_d = sh_inv_q;
    sh_str_d = sh_str_q;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (wr_edge && idx_ok && (cfg.cfg_out_idx == IDX_W'(o))) begin
        sh_src_d[o] = cfg.cfg_src;
        sh_inv_d[o] = cfg.cfg_invert;
        sh_str_d[o] = cfg.cfg_stretch;
      end
    end
  end

  always_comb begin
    ack_d = ack_q ^ (wr_edge | cm_edge);
    err_d = err_q;
    if (cm_edge) begin
      err_d = 1'b0;
    end else if (wr_edge && !idx_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        sh_src_q[o]  <= SRC_ZERO;
        sh_str_q[o]  <= '0;
        act_src_q[o] <= SRC_ZERO;
        act_str_q[o] <= '0;
      end
      sh_inv_q  <= '0;
      act_inv_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sh_src_q <= sh_src_d;
      sh_inv_q <= sh_inv_d;
      sh_str_q <= sh_str_d;
      if (cm_edge) begin
        act_src_q <= sh_src_d;
        act_inv_q <= sh_inv_d;
        act_str_q <= sh_str_d;
      end
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  // Source select: out-of-range codes fall through to constant 0.
  always_comb begin
    s_line = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      logic pick;
      pick = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (act_src_q[o] == SRC_W'(i)) pick = in_s[i];
      end
      if (act_src_q[o] == SRC_ONE) pick = 1'b1;
      s_line[o] = pick ^ act_inv_q[o];
    end
  end

  // Stretcher: the running count is never cut short by a commit.
  always_comb begin
    out_d = '0;
    cnt_d = cnt_q;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (s_line[o] && !s_prev_q[o] && (act_str_q[o] != '0)) begin
        cnt_d[o] = act_str_q[o] - STR_ONE;
      end else if (cnt_q[o] != '0) begin
        cnt_d[o] = cnt_q[o] - STR_ONE;
      end
      out_d[o] = s_line[o] | (cnt_q[o] != '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int o = 0; o < NUM_OUT; o++) cnt_q[o] <= '0;
      s_prev_q <= '0;
      out_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      s_prev_q <= s_line;
      out_q    <= out_d;
    end
  end
endmodule

// File: tb/tb_line_matrix_v2.sv
// tb/tb_line_matrix_v2.sv - directed self-checking bench for line_matrix_v2
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_line_matrix_v2;
  localparam int NUM_IN  = 8;
  localparam int NUM_OUT = 9;
  localparam int SYNC    = 2;
  localparam int SW      = 8;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NUM_IN-1:0]   input_lines;
  logic [NUM_OUT-1:0]  output_lines;
  int                  checks = 0;
  int                  errors = 0;
  int                  run_cur = 0;
  int                  last_run = 0;
  logic                prev_ack;
  logic                want;

  line_matrix_v2_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .STRETCH_W(SW)) cfg_if ();

  line_matrix_v2 #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC), .STRETCH_W(SW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .input_lines  (input_lines),
    .output_lines (output_lines),
    .cfg          (cfg_if)
  );

  always #5 clk = ~clk;

  // Length of the most recent completed high run on output 2
  always @(negedge clk) begin
    if (output_lines[2]) begin
      run_cur = run_cur + 1;
    end else begin
      if (run_cur != 0) last_run = run_cur;
      run_cur = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic prev);
    int   n;
    logic exp_ack;
    n = 0;
    exp_ack = !prev;
    while (cfg_if.cfg_ack === prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ack_toggle", 32'(cfg_if.cfg_ack), 32'(exp_ack));
  endtask

  task automatic cfg_write(input int idx, input int src, input int inv, input int str);
    logic p;
    cfg_if.cfg_out_idx = 4'(idx);
    cfg_if.cfg_src     = 4'(src);
    cfg_if.cfg_invert  = 1'(inv);
    cfg_if.cfg_stretch = 8'(str);
    p = cfg_if.cfg_ack;
    cfg_if.cfg_wr = 1'b1;
    wait_ack(p);
    cfg_if.cfg_wr = 1'b0;
    tick(SYNC + 2);
  endtask

  task automatic cfg_commit_t();
    logic p;
    p = cfg_if.cfg_ack;
    cfg_if.cfg_commit = 1'b1;
    wait_ack(p);
    cfg_if.cfg_commit = 1'b0;
    tick(SYNC + 2);
  endtask

  initial begin
    input_lines        = 8'hFF;
    cfg_if.cfg_wr      = 1'b0;
    cfg_if.cfg_commit  = 1'b0;
    cfg_if.cfg_out_idx = '0;
    cfg_if.cfg_src     = '0;
    cfg_if.cfg_invert  = 1'b0;
    cfg_if.cfg_stretch = '0;
    tick(3);
    rstn = 1'b1;
    tick(5);

    // Reset state with no configuration
    chk("reset_out", 32'(output_lines), 32'h000);
    chk("reset_ack", 32'(cfg_if.cfg_ack), 32'h0);
    chk("reset_err", 32'(cfg_if.cfg_err), 32'h0);
    input_lines = 8'h00;
    tick(4);

    // Route input 5 to output 3 and measure latency
    cfg_write(3, 5, 0, 0);
    cfg_commit_t();
    chk("ack_twice", 32'(cfg_if.cfg_ack), 32'h0);
    input_lines[5] = 1'b1;
    tick(2);
    chk("lat_rise_early", 32'(output_lines[3]), 32'h0);
    tick(1);
    chk("lat_rise", 32'(output_lines[3]), 32'h1);
    input_lines[5] = 1'b0;
    tick(2);
    chk("lat_fall_early", 32'(output_lines[3]), 32'h1);
    tick(1);
    chk("lat_fall", 32'(output_lines[3]), 32'h0);

    // Shadow writes are invisible until commit; last write wins
    cfg_write(0, NUM_IN + 1, 1, 0);
    tick(4);
    chk("shadow_hidden1", 32'(output_lines[0]), 32'h0);
    cfg_write(0, NUM_IN + 1, 0, 0);
    tick(4);
    chk("shadow_hidden2", 32'(output_lines[0]), 32'h0);
    prev_ack = cfg_if.cfg_ack;
    cfg_if.cfg_commit = 1'b1;
    wait_ack(prev_ack);
    chk("commit_cycle", 32'(output_lines[0]), 32'h0);
    tick(1);
    chk("commit_plus1", 32'(output_lines[0]), 32'h1);
    cfg_if.cfg_commit = 1'b0;
    tick(SYNC + 2);

    // Pulse stretching on output 2 from input 1
    cfg_write(2, 1, 0, 5);
    cfg_commit_t();
    last_run = 0;
    input_lines[1] = 1'b1;
    tick(1);
    input_lines[1] = 1'b0;
    tick(12);
    chk("stretch_short", 32'(last_run), 32'd5);
    last_run = 0;
    input_lines[1] = 1'b1;
    tick(12);
    input_lines[1] = 1'b0;
    tick(10);
    chk("stretch_long", 32'(last_run), 32'd12);
    last_run = 0;
    input_lines[1] = 1'b1;
    tick(1);
    input_lines[1] = 1'b0;
    tick(2);
    input_lines[1] = 1'b1;
    tick(1);
    input_lines[1] = 1'b0;
    tick(15);
    chk("stretch_retrig", 32'(last_run), 32'd8);

    // Inverted route and out-of-range write
    cfg_write(1, 0, 1, 0);
    cfg_commit_t();
    chk("invert_low_in", 32'(output_lines[1]), 32'h1);
    input_lines[0] = 1'b1;
    tick(4);
    chk("invert_high_in", 32'(output_lines[1]), 32'h0);
    input_lines[0] = 1'b0;
    tick(4);
    chk("invert_back", 32'(output_lines[1]), 32'h1);
    cfg_write(9, 6, 1, 3);
    chk("err_set", 32'(cfg_if.cfg_err), 32'h1);
    chk("err_out_pre", 32'(output_lines), 32'h003);
    cfg_commit_t();
    chk("err_cleared", 32'(cfg_if.cfg_err), 32'h0);
    chk("err_tables", 32'(output_lines), 32'h003);

    // Write and commit strobes together
    cfg_if.cfg_out_idx = 4'd4;
    cfg_if.cfg_src     = 4'(NUM_IN + 1);
    cfg_if.cfg_invert  = 1'b0;
    cfg_if.cfg_stretch = 8'd0;
    prev_ack = cfg_if.cfg_ack;
    want = !prev_ack;
    cfg_if.cfg_wr     = 1'b1;
    cfg_if.cfg_commit = 1'b1;
    wait_ack(prev_ack);
    tick(1);
    chk("simul_out4", 32'(output_lines[4]), 32'h1);
    tick(6);
    chk("simul_ack_once", 32'(cfg_if.cfg_ack), 32'(want));
    cfg_if.cfg_wr     = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    tick(4);
    chk("simul_ack_stable", 32'(cfg_if.cfg_ack), 32'(want));
    chk("simul_all", 32'(output_lines), 32'h013);

    // Asynchronous reset in the middle of a stretch
    input_lines[1] = 1'b1;
    tick(1);
    input_lines[1] = 1'b0;
    tick(4);
    chk("mid_stretch_high", 32'(output_lines[2]), 32'h1);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_out", 32'(output_lines), 32'h000);
    chk("async_rst_ack", 32'(cfg_if.cfg_ack), 32'h0);
    chk("async_rst_err", 32'(cfg_if.cfg_err), 32'h0);
    tick(2);
    rstn = 1'b1;
    input_lines = 8'hFF;
    tick(6);
    chk("post_rst_out", 32'(output_lines), 32'h000);
    cfg_commit_t();
    chk("post_rst_commit_out", 32'(output_lines), 32'h000);
    chk("post_rst_ack", 32'(cfg_if.cfg_ack), 32'h1);
    chk("post_rst_err", 32'(cfg_if.cfg_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
